// File: rtl/cim_bitserial_column_if.sv
// Job/result bundle for one bit-serial CIM column: the master supplies weights, activations and start,
// and consumes the signed dot product over the out_valid/out_ready handshake.
interface cim_bitserial_column_if #(
    parameter int WORDLEN      = 8,
    parameter int NROWS        = 64,
    parameter int LOG2_NROWS   = 6,
    parameter int IA_BITS      = 8,
    parameter int LOG2_IA_BITS = 3,
    parameter int OUT_WIDTH    = WORDLEN + LOG2_NROWS + IA_BITS
);
    logic [NROWS-1:0][WORDLEN-1:0] weight;
    logic [NROWS-1:0][IA_BITS-1:0] ia_data;
    logic [LOG2_IA_BITS:0]         ia_prec;
    logic                          ia_signed;
    logic                          start;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_WIDTH-1:0]          sum;

    modport master (
        output weight, ia_data, ia_prec, ia_signed, start, out_ready,
        input  busy, out_valid, sum
    );

    modport slave (
        input  weight, ia_data, ia_prec, ia_signed, start, out_ready,
        output busy, out_valid, sum
    );
endinterface

// File: rtl/cim_bitserial_column.sv
// Bit-serial CIM column: LSB-first activation shift through a 1-bit-multiply adder tree, shift-accumulate.
// Result valid P+1 edges after start acceptance; holds sum/out_valid in HOLD until out_ready, start ignored unless IDLE.
module cim_bitserial_column #(
    parameter int WORDLEN      = 8,
    parameter int NROWS        = 64,
    parameter int LOG2_NROWS   = 6,
    parameter int IA_BITS      = 8,
    parameter int LOG2_IA_BITS = 3,
    parameter int OUT_WIDTH    = WORDLEN + LOG2_NROWS + IA_BITS
) (
    input  logic                   clock,
    input  logic                   resetn,
    cim_bitserial_column_if.slave  bus
);
    localparam int TW = WORDLEN + LOG2_NROWS;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_t;

    state_t                        r_state;
    logic [NROWS-1:0][IA_BITS-1:0] r_ia;
    logic [LOG2_IA_BITS-1:0]       r_last_b;
    logic                          r_signed;
    logic [LOG2_IA_BITS-1:0]       r_b;
    logic signed [TW-1:0]          r_tree;
    logic [LOG2_IA_BITS-1:0]       r_tree_b;
    logic                          r_tree_msb;
    logic                          r_tree_vld;
    logic signed [OUT_WIDTH-1:0]   r_accum;
    logic signed [OUT_WIDTH-1:0]   r_sum;
    logic                          r_out_valid;

    logic signed [TW-1:0]          w_treesum;
    logic signed [OUT_WIDTH-1:0]   w_term;
    logic signed [OUT_WIDTH-1:0]   w_accum_next;
    logic [LOG2_IA_BITS:0]         w_prec_m1;

    // Out-of-range precision (0 or above IA_BITS) falls back to the full word.
    always_comb begin
        w_prec_m1 = (LOG2_IA_BITS+1)'(IA_BITS - 1);
        if (bus.ia_prec != '0 && bus.ia_prec <= (LOG2_IA_BITS+1)'(IA_BITS))
            w_prec_m1 = bus.ia_prec - 1'b1;
    end

    always_comb begin
        w_treesum = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (r_ia[r][r_b])
                w_treesum = w_treesum + TW'($signed(bus.weight[r]));
        end
    end

    // MSB of a two's-complement activation carries negative weight.
    always_comb begin
        w_term       = OUT_WIDTH'(r_tree) <<< r_tree_b;
        w_accum_next = r_accum;
        if (r_tree_vld) begin
            if (r_signed && r_tree_msb)
                w_accum_next = r_accum - w_term;
            else
                w_accum_next = r_accum + w_term;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_ia        <= '0;
            r_last_b    <= '0;
            r_signed    <= 1'b0;
            r_b         <= '0;
            r_tree      <= '0;
            r_tree_b    <= '0;
            r_tree_msb  <= 1'b0;
            r_tree_vld  <= 1'b0;
            r_accum     <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tree_vld <= 1'b0;
                    if (bus.start) begin
                        r_ia     <= bus.ia_data;
                        r_last_b <= w_prec_m1[LOG2_IA_BITS-1:0];
                        r_signed <= bus.ia_signed;
                        r_accum  <= '0;
                        r_b      <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_accum    <= w_accum_next;
                    r_tree     <= w_treesum;
                    r_tree_b   <= r_b;
                    r_tree_msb <= (r_b == r_last_b);
                    r_tree_vld <= 1'b1;
                    r_b        <= r_b + 1'b1;
                    if (r_b == r_last_b)
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    r_accum     <= w_accum_next;
                    r_sum       <= w_accum_next;
                    r_tree_vld  <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
endmodule

// File: tb/tb_cim_bitserial_column.sv
// Directed vector bench for cim_bitserial_column: table of uniform/row-0 jobs plus backpressure and reset sequences.
module tb_cim_bitserial_column;
    localparam int NROWS = 64;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_errors;

    cim_bitserial_column_if #(.WORDLEN(8), .NROWS(64), .LOG2_NROWS(6), .IA_BITS(8), .LOG2_IA_BITS(3)) bus ();

    cim_bitserial_column #(
        .WORDLEN(8), .NROWS(64), .LOG2_NROWS(6), .IA_BITS(8), .LOG2_IA_BITS(3)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          w_all;
        int          w_row0;
        logic [7:0]  ia_all;
        logic [7:0]  ia_row0;
        logic [3:0]  prec;
        logic        sgn;
        longint      exp_sum;
        int          exp_lat;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        logic [7:0] w0, wa;
        w0 = v.w_row0[7:0];
        wa = v.w_all[7:0];
        for (int r = 0; r < NROWS; r++) begin
            bus.weight[r]  = (r == 0) ? w0 : wa;
            bus.ia_data[r] = (r == 0) ? v.ia_row0 : v.ia_all;
        end
        bus.ia_prec   = v.prec;
        bus.ia_signed = v.sgn;
    endtask

    function automatic longint sum_val();
        return longint'($signed(bus.sum));
    endfunction

    // Waits for out_valid from the current edge count; returns the edge number or -1 on timeout.
    task automatic wait_valid(input int from, output int lat, output int busy_drops);
        lat = -1;
        busy_drops = 0;
        for (int n = from; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (!bus.busy) busy_drops++;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_job(input string tag, input vec_t v);
        int lat, drops;
        @(negedge clock);
        load(v);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        // Scramble sampled-at-accept inputs; the job must use the latched copies.
        for (int r = 0; r < NROWS; r++) bus.ia_data[r] = ~bus.ia_data[r];
        bus.ia_prec   = 4'd2;
        bus.ia_signed = ~v.sgn;
        check({tag, "_busy_accept"}, longint'(bus.busy), 1);
        wait_valid(1, lat, drops);
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_sum"}, sum_val(), v.exp_sum);
        check({tag, "_busy_drops"}, drops, 0);
        @(posedge clock);
        #1;
        check({tag, "_consumed"}, {bus.out_valid, bus.busy}, 0);
    endtask

    initial begin
        int lat, drops, bad;
        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{1,    1,    8'hFF, 8'hFF, 4'd8, 1'b0, 16320,   9};
        tbl[1]  = '{3,    3,    8'hFF, 8'hFF, 4'd8, 1'b1, -192,    9};
        tbl[2]  = '{3,    3,    8'hFF, 8'hFF, 4'd8, 1'b0, 48960,   9};
        tbl[3]  = '{0,    -128, 8'h80, 8'h80, 4'd8, 1'b1, 16384,   9};
        tbl[4]  = '{5,    -128, 8'h00, 8'h7F, 4'd8, 1'b0, -16256,  9};
        tbl[5]  = '{2,    2,    8'h05, 8'h05, 4'd3, 1'b0, 640,     4};
        tbl[6]  = '{2,    2,    8'h05, 8'h05, 4'd3, 1'b1, -384,    4};
        tbl[7]  = '{2,    2,    8'h85, 8'h85, 4'd0, 1'b0, 17024,   9};
        tbl[8]  = '{-128, -128, 8'h80, 8'h80, 4'd9, 1'b1, 1048576, 9};
        tbl[9]  = '{7,    7,    8'h01, 8'h01, 4'd1, 1'b1, -448,    2};
        tbl[10] = '{-2,   -2,   8'hF3, 8'hF3, 4'd5, 1'b1, 1664,    6};
        tbl[11] = '{1,    1,    8'h01, 8'h01, 4'd1, 1'b0, 64,      2};

        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        load(tbl[0]);
        #12;
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_sum", sum_val(), 0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++)
            run_job($sformatf("vec%0d", i), tbl[i]);

        // Backpressure: start pulses in RUN and HOLD must be ignored.
        @(negedge clock);
        load(tbl[0]);
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_valid(4, lat, drops);
        check("bp_latency", lat, 9);
        check("bp_busy_drops", drops, 0);
        check("bp_sum", sum_val(), 16320);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                for (int r = 0; r < NROWS; r++) bus.ia_data[r] = 8'h00;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (!bus.out_valid || !bus.busy || sum_val() != 16320) bad++;
        end
        bus.start = 1'b0;
        check("bp_hold_stable_cycles_bad", bad, 0);
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_out_valid", longint'(bus.out_valid), 0);
        check("bp_release_busy", longint'(bus.busy), 0);
        check("bp_sum_retained", sum_val(), 16320);
        @(negedge clock);
        load(tbl[11]);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("bp_restart_accept", longint'(bus.busy), 1);
        wait_valid(1, lat, drops);
        check("bp_restart_latency", lat, 2);
        check("bp_restart_sum", sum_val(), 64);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of RUN.
        @(negedge clock);
        load(tbl[2]);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_busy", longint'(bus.busy), 0);
        check("rst_mid_out_valid", longint'(bus.out_valid), 0);
        check("rst_mid_sum", sum_val(), 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        check("rst_no_partial_result", longint'(bus.out_valid), 0);
        run_job("post_reset", tbl[11]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
